// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Plays a 16-entry {note, beats} pattern into a tone divider,
//               one step per PLAY phase. Optional inter-note silence is
//               enabled by defining NOTE_SEQUENCER_GAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int TICK_DIV = 25_000_000,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_note,
    input  logic [3:0] wr_beats,
    input  logic [4:0] seq_len,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [7:0] note_code,
    output logic [3:0] step_idx,
    output logic       busy,
    output logic       done
);

    localparam int            c_TW        = $clog2(TICK_DIV);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_TW-1:0] r_tick,  w_tick_nxt;
    logic [4:0]      r_beats, w_beats_nxt;
    logic [4:0]      r_len,   w_len_nxt;
    logic [7:0]      r_note,  w_note_nxt;
    logic [3:0]      r_step,  w_step_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;

    logic [11:0] r_mem [DEPTH];
    logic [4:0]  w_step_inc;
    logic        w_last;
    logic [3:0]  w_adv_idx;
    logic [3:0]  w_rd_addr;
    logic [11:0] w_rd;
    logic [4:0]  w_rd_beats;
    logic        w_tick_wrap;
    logic        w_abort;
    logic        w_advance;

    // Pattern memory has no reset so a reset mid-play keeps the programmed tune.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= {wr_note, wr_beats};
        end
    end

    assign w_step_inc  = {1'b0, r_step} + 5'd1;
    assign w_last      = (w_step_inc >= r_len);
    assign w_adv_idx   = w_last ? 4'd0 : w_step_inc[3:0];
    assign w_rd_addr   = (r_state == S_IDLE) ? 4'd0 : w_adv_idx;
    assign w_rd        = r_mem[w_rd_addr];
    assign w_rd_beats  = (w_rd[3:0] == 4'd0) ? 5'd16 : {1'b0, w_rd[3:0]};
    assign w_tick_wrap = (r_tick == c_TICK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick + c_TW'(1);
        w_beats_nxt = r_beats;
        w_len_nxt   = r_len;
        w_note_nxt  = r_note;
        w_step_nxt  = r_step;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_abort     = 1'b0;
        w_advance   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (start && !stop) begin
                    if (seq_len != 5'd0) begin
                        w_state_nxt = S_PLAY;
                        w_len_nxt   = (seq_len > 5'd16) ? 5'd16 : seq_len;
                        w_step_nxt  = 4'd0;
                        w_note_nxt  = w_rd[11:4];
                        w_beats_nxt = w_rd_beats;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_abort = 1'b1;
                end else if (w_tick_wrap) begin
                    w_tick_nxt  = '0;
                    w_beats_nxt = r_beats - 5'd1;
                    if (r_beats == 5'd1) begin
`ifdef NOTE_SEQUENCER_GAP_EN
                        w_state_nxt = S_GAP;
                        w_note_nxt  = 8'd0;
`else
                        w_advance   = 1'b1;
`endif
                    end
                end
            end
`ifdef NOTE_SEQUENCER_GAP_EN
            S_GAP: begin
                if (stop) begin
                    w_abort = 1'b1;
                end else if (w_tick_wrap) begin
                    w_advance = 1'b1;
                end
            end
`endif
            default: w_abort = 1'b1;
        endcase

        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_tick_nxt  = '0;
            w_beats_nxt = 5'd0;
            w_note_nxt  = 8'd0;
            w_step_nxt  = 4'd0;
            w_busy_nxt  = 1'b0;
        end else if (w_advance) begin
            w_tick_nxt = '0;
            if (!w_last || loop) begin
                w_state_nxt = S_PLAY;
                w_step_nxt  = w_adv_idx;
                w_note_nxt  = w_rd[11:4];
                w_beats_nxt = w_rd_beats;
            end else begin
                w_state_nxt = S_IDLE;
                w_beats_nxt = 5'd0;
                w_note_nxt  = 8'd0;
                w_step_nxt  = 4'd0;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_beats <= 5'd0;
            r_len   <= 5'd0;
            r_note  <= 8'd0;
            r_step  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_beats <= w_beats_nxt;
            r_len   <= w_len_nxt;
            r_note  <= w_note_nxt;
            r_step  <= w_step_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign note_code = r_note;
    assign step_idx  = r_step;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000: CLK cycles per beat tick (0.25 s at 100 MHz); legal range 2..2^26.
REQ-002 Parameter DEPTH, default 16: pattern memory entries; fixed at 16 in this revision.
REQ-003 CLK  in  1  system clock; every register updates on its rising edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 WR_EN  in  1  write strobe for pattern memory.
REQ-006 WR_ADDR  in  4  pattern entry address.
REQ-007 WR_NOTE  in  8  note code, in the same encoding as the switch-driven tone divider's SW input; 0 = silence.
REQ-008 WR_BEATS  in  4  note duration in beat ticks; 0 means 16.
REQ-009 SEQ_LEN  in  5  number of steps to play (0..16), sampled on accepted START.
REQ-010 START  in  1  level-sampled play request.
REQ-011 STOP  in  1  level-sampled abort.
REQ-012 LOOP  in  1  wrap to step 0 after the last step instead of finishing; sampled at end of each pass.
REQ-013 NOTE_CODE  out  8  registered code driven straight to the tone divider's SW input.
REQ-014 STEP_IDX  out  4  index of the current step.
REQ-015 BUSY  out  1  high in PLAY or GAP.
REQ-016 DONE  out  1  one-cycle pulse on normal completion.

Function
REQ-017 FSM states are IDLE, PLAY and GAP; all outputs are registered.
REQ-018 Pattern memory is 16 x 12 bits (note and beats); writes take effect at the next edge, in any state.
REQ-019 IDLE: when START=1, STOP=0 and SEQ_LEN>0, the next edge enters PLAY with STEP_IDX=0 and NOTE_CODE=mem[0].note, latches SEQ_LEN, and sets BUSY=1.
REQ-020 IDLE with START=1 and SEQ_LEN=0: stay in IDLE, BUSY stays 0, and DONE pulses on the next cycle.
REQ-021 START while BUSY=1 is ignored.
REQ-022 On entering PLAY, the step's note and beats are latched, and a later write to that address does not alter the step in progress.
REQ-023 The tick counter clears on every state entry and counts 0..TICK_DIV-1; the beat counter decrements on each wrap.
REQ-024 PLAY lasts exactly beats x TICK_DIV cycles, with beats=0 treated as 16.
REQ-025 At the end of PLAY, the block enters GAP (see Configuration) or advances directly to the next step.
REQ-026 Advance: if STEP_IDX+1 < latched length, enter PLAY for STEP_IDX+1.
REQ-027 Advance at the last step with LOOP=1: enter PLAY for step 0 with no extra cycle.
REQ-028 Advance at the last step with LOOP=0: enter IDLE, pulse DONE for one cycle, clear NOTE_CODE and BUSY at the same edge.
REQ-029 STOP=1 in PLAY or GAP: enter IDLE at the next edge with NOTE_CODE=0, BUSY=0 and STEP_IDX=0; DONE is not pulsed.
REQ-030 START and STOP asserted together: STOP wins.
REQ-031 STEP_IDX is 4 bits and wraps 15->0 only through the loop path.

Reset
REQ-032 RST_N low forces, asynchronously: IDLE, NOTE_CODE=0, STEP_IDX=0, BUSY=0, DONE=0, and both counters to 0.
REQ-033 Reset does not clear pattern memory; its contents are undefined after power-up.
REQ-034 Reset asserted mid-play aborts immediately; after release the block waits in IDLE for START.

Configuration
REQ-035 Macro NOTE_SEQUENCER_GAP_EN defined: after each PLAY the block spends exactly TICK_DIV cycles in GAP with NOTE_CODE=0 and BUSY=1, then advances per REQ-026..028.
REQ-036 Macro NOTE_SEQUENCER_GAP_EN undefined: GAP is not implemented, and steps run back-to-back with NOTE_CODE changing on the cycle PLAY ends.

Verification (TICK_DIV=4)
REQ-037 Write mem[0]={0x21,2}, mem[1]={0x45,1}, SEQ_LEN=2, LOOP=0, pulse START -> NOTE_CODE=0x21 for 8 cycles, then 0 for 4 (gap build), then 0x45 for 4, then 0 for 4; DONE pulses once and BUSY falls on the same edge.
REQ-038 Same pattern with LOOP=1 and no gap -> sequence 0x21 x8, 0x45 x4, 0x21 x8 with no idle cycle between passes; DONE never pulses.
REQ-039 STOP asserted on the 3rd cycle of step 0 -> next cycle NOTE_CODE=0, BUSY=0, STEP_IDX=0, DONE=0.
REQ-040 WR_BEATS=0 on a single step -> NOTE_CODE held for 64 cycles.
REQ-041 START with SEQ_LEN=0 -> DONE high for exactly 1 cycle and BUSY stays 0; START and STOP together -> stays IDLE.
REQ-042 RST_N pulsed low mid-PLAY, asynchronous to CLK -> outputs 0 immediately; after release, a fresh START replays from step 0 with the previously written memory intact.
